// File: rtl/pvr_setup_pkg.sv
// Shared types, limits and fixed-point helpers for the triangle plane-equation setup engine.
// Everything here is combinational and shared by the setup datapath and its divider.
package pvr_setup_pkg;

  typedef logic signed [63:0]  s64_t;
  typedef logic signed [127:0] s128_t;

  typedef enum logic [2:0] {
    StIdle,
    StDiff,
    StMul,
    StCross,
    StDivX,
    StDivY,
    StCmul,
    StCsum
  } state_e;

  localparam int unsigned MAX_FRAC = 16;
  localparam s64_t S64_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam s64_t S64_MIN = 64'sh8000_0000_0000_0000;

  // Saturation limits of a w-bit signed result, widened for comparison.
  function automatic s128_t sat_max(input int unsigned w);
    return (s128_t'(1) <<< (w - 1)) - s128_t'(1);
  endfunction

  function automatic s128_t sat_min(input int unsigned w);
    return -(s128_t'(1) <<< (w - 1));
  endfunction

  function automatic s64_t sext32(input logic signed [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Full-precision signed product, arithmetic-shifted right by the fraction bits.
  function automatic s128_t mul_shr(input s64_t a, input s64_t b, input logic [4:0] f);
    s128_t p;
    p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
    return p >>> f;
  endfunction

  function automatic s64_t m64(input s64_t a, input s64_t b, input logic [4:0] f);
    return s64_t'(mul_shr(a, b, f));
  endfunction

  // Left shift by the fraction bits, clamped to the 64-bit signed range.
  function automatic s64_t shl_clamp(input s64_t v, input logic [4:0] f);
    logic signed [79:0] w;
    w = {{16{v[63]}}, v};
    w = w <<< f;
    if (w[79:63] != {17{w[79]}}) return w[79] ? S64_MIN : S64_MAX;
    return w[63:0];
  endfunction

endpackage

// File: rtl/plane_setup_if.sv
// Request/result bundle between a triangle producer and the plane setup engine.
// The master drives vertices and start; the slave returns coefficients and status.
interface plane_setup_if #(
  parameter int unsigned OUT_W = 32
);
  logic                    start;
  logic                    ready;
  logic [7:0]              FRAC_BITS;
  logic signed [31:0]      FX1, FX2, FX3;
  logic signed [31:0]      FY1, FY2, FY3;
  logic signed [31:0]      FZ1, FZ2, FZ3;
  logic signed [OUT_W-1:0] FDDX, FDDY, c;
  logic                    done;
  logic                    coef_valid;
  logic                    degenerate;
  logic                    sat;

  modport master (
    output start, FRAC_BITS, FX1, FX2, FX3, FY1, FY2, FY3, FZ1, FZ2, FZ3,
    input  ready, FDDX, FDDY, c, done, coef_valid, degenerate, sat
  );

  modport slave (
    input  start, FRAC_BITS, FX1, FX2, FX3, FY1, FY2, FY3, FZ1, FZ2, FZ3,
    output ready, FDDX, FDDY, c, done, coef_valid, degenerate, sat
  );
endinterface

// File: rtl/seq_div_s64.sv
// Signed iterative restoring divider: one quotient bit per clock, DIV_ITER clocks per divide.
// Magnitudes are divided and the sign applied afterwards, so quotients truncate toward zero.
module seq_div_s64
  import pvr_setup_pkg::*;
#(
  parameter int unsigned DIV_ITER = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic go,
  input  s64_t dividend,
  input  s64_t divisor,
  output s64_t quotient,
  output logic busy,
  output logic done
);
  localparam int unsigned CntW = $clog2(DIV_ITER + 1);

  logic [63:0]     rem_q, quo_q, den_q;
  logic            neg_q, done_q;
  logic [CntW-1:0] cnt_q;

  logic [63:0] rem_src, quo_src, den_src, rem_nxt, quo_nxt;
  logic [64:0] trial;

  function automatic logic [63:0] mag(input s64_t v);
    return v[63] ? (~unsigned'(v) + 64'd1) : unsigned'(v);
  endfunction

  // The go edge already performs the first iteration, keeping the divide at DIV_ITER clocks.
  always_comb begin
    rem_src = go ? 64'd0 : rem_q;
    quo_src = go ? mag(dividend) : quo_q;
    den_src = go ? mag(divisor) : den_q;
    trial   = {rem_src, quo_src[63]} - {1'b0, den_src};
    if (trial[64]) begin
      rem_nxt = {rem_src[62:0], quo_src[63]};
      quo_nxt = {quo_src[62:0], 1'b0};
    end else begin
      rem_nxt = trial[63:0];
      quo_nxt = {quo_src[62:0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (go) begin
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
      den_q  <= den_src;
      neg_q  <= dividend[63] ^ divisor[63];
      cnt_q  <= CntW'(DIV_ITER - 1);
      done_q <= (DIV_ITER == 1);
    end else if (cnt_q != '0) begin
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
      cnt_q  <= cnt_q - 1'b1;
      done_q <= (cnt_q == CntW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  // Only MIN / -1 can overflow a positive quotient; clamp rather than wrap.
  always_comb begin
    if (neg_q)          quotient = s64_t'(~quo_q + 64'd1);
    else if (quo_q[63]) quotient = S64_MAX;
    else                quotient = s64_t'(quo_q);
  end

  assign busy = (cnt_q != '0);
  assign done = done_q;

endmodule

// File: rtl/plane_setup.sv
// Triangle plane-equation setup: attr(x,y) = x*FDDX + y*FDDY + c from three vertices.
// Fixed latency of 5 + 2*DIV_ITER clocks; coefficients hold until the next completion.
module plane_setup
  import pvr_setup_pkg::*;
#(
  parameter int unsigned DIV_ITER = 64,
  parameter int unsigned OUT_W    = 32
) (
  input logic          clock,
  input logic          reset,
  plane_setup_if.slave bus
);
  localparam int unsigned CntW = $clog2(DIV_ITER + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      f_q;

  logic signed [31:0] x1_q, x2_q, x3_q, y1_q, y2_q, y3_q, z1_q, z2_q, z3_q;
  s64_t dx21_q, dx31_q, dy21_q, dy31_q, dz21_q, dz31_q;
  s64_t pa0_q, pa1_q, pb0_q, pb1_q, pc0_q, pc1_q;
  s64_t aa_q, ba_q, cc_q, qx_q, qy_q;
  s128_t px_q, py_q;

  logic signed [OUT_W-1:0] fddx_q, fddy_q, c_q;
  logic done_q, valid_q, degen_q, sat_q;

  logic           degen, last_iter, div_go, div_busy, div_done, unused_div;
  s64_t           div_dividend, div_quot, qy_w;
  s128_t          csum;
  logic [OUT_W:0] fddx_sat, fddy_sat, c_sat;

  // Returns {clamped, value} for a wide signed result.
  function automatic logic [OUT_W:0] clamp_out(input s128_t v);
    s128_t hi, lo;
    hi = sat_max(OUT_W);
    lo = sat_min(OUT_W);
    if (v > hi) return {1'b1, hi[OUT_W-1:0]};
    if (v < lo) return {1'b1, lo[OUT_W-1:0]};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  always_comb begin
    degen        = (cc_q == '0);
    last_iter    = (cnt_q == CntW'(DIV_ITER - 1));
    // With C==0 the divider is never started, but the states still run their full length.
    div_go       = (state_q inside {StDivX, StDivY}) && (cnt_q == '0) && !degen;
    div_dividend = shl_clamp((state_q == StDivY) ? ba_q : aa_q, f_q);
    qy_w         = degen ? '0 : div_quot;
    csum         = {{96{z1_q[31]}}, z1_q};
    csum         = csum - px_q - py_q;
    fddx_sat     = clamp_out({{64{qx_q[63]}}, qx_q});
    fddy_sat     = clamp_out({{64{qy_q[63]}}, qy_q});
    c_sat        = clamp_out(csum);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StDiff;
      StDiff:  state_d = StMul;
      StMul:   state_d = StCross;
      StCross: begin
        state_d = StDivX;
        cnt_d   = '0;
      end
      StDivX: begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = StDivY;
          cnt_d   = '0;
        end
      end
      StDivY: begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = StCmul;
          cnt_d   = '0;
        end
      end
      StCmul:  state_d = StCsum;
      StCsum:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      f_q    <= '0;
      x1_q   <= '0; x2_q <= '0; x3_q <= '0;
      y1_q   <= '0; y2_q <= '0; y3_q <= '0;
      z1_q   <= '0; z2_q <= '0; z3_q <= '0;
      dx21_q <= '0; dx31_q <= '0; dy21_q <= '0;
      dy31_q <= '0; dz21_q <= '0; dz31_q <= '0;
      pa0_q  <= '0; pa1_q <= '0; pb0_q <= '0;
      pb1_q  <= '0; pc0_q <= '0; pc1_q <= '0;
      aa_q   <= '0; ba_q <= '0; cc_q <= '0;
      qx_q   <= '0; qy_q <= '0;
      px_q   <= '0; py_q <= '0;
      fddx_q <= '0; fddy_q <= '0; c_q <= '0;
      done_q <= 1'b0; valid_q <= 1'b0; degen_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: if (bus.start) begin
          x1_q <= bus.FX1; x2_q <= bus.FX2; x3_q <= bus.FX3;
          y1_q <= bus.FY1; y2_q <= bus.FY2; y3_q <= bus.FY3;
          z1_q <= bus.FZ1; z2_q <= bus.FZ2; z3_q <= bus.FZ3;
          f_q  <= (bus.FRAC_BITS > 8'(MAX_FRAC)) ? 5'(MAX_FRAC) : bus.FRAC_BITS[4:0];
          valid_q <= 1'b0;
        end
        StDiff: begin
          dx21_q <= sext32(x2_q) - sext32(x1_q);
          dx31_q <= sext32(x3_q) - sext32(x1_q);
          dy21_q <= sext32(y2_q) - sext32(y1_q);
          dy31_q <= sext32(y3_q) - sext32(y1_q);
          dz21_q <= sext32(z2_q) - sext32(z1_q);
          dz31_q <= sext32(z3_q) - sext32(z1_q);
        end
        StMul: begin
          pa0_q <= m64(dz31_q, dy21_q, f_q);
          pa1_q <= m64(dz21_q, dy31_q, f_q);
          pb0_q <= m64(dx31_q, dz21_q, f_q);
          pb1_q <= m64(dx21_q, dz31_q, f_q);
          pc0_q <= m64(dx31_q, dy21_q, f_q);
          pc1_q <= m64(dx21_q, dy31_q, f_q);
        end
        StCross: begin
          aa_q <= pa0_q - pa1_q;
          ba_q <= pb0_q - pb1_q;
          cc_q <= pc0_q - pc1_q;
        end
        // The X quotient is complete on the first DIV_Y cycle, as the Y divide is launched.
        StDivY: if (cnt_q == '0) qx_q <= degen ? '0 : div_quot;
        StCmul: begin
          qy_q <= qy_w;
          px_q <= mul_shr(qx_q, sext32(x1_q), f_q);
          py_q <= mul_shr(qy_w, sext32(y1_q), f_q);
        end
        StCsum: begin
          fddx_q  <= fddx_sat[OUT_W-1:0];
          fddy_q  <= fddy_sat[OUT_W-1:0];
          c_q     <= c_sat[OUT_W-1:0];
          sat_q   <= fddx_sat[OUT_W] | fddy_sat[OUT_W] | c_sat[OUT_W];
          degen_q <= degen;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  seq_div_s64 #(
    .DIV_ITER(DIV_ITER)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .go       (div_go),
    .dividend (div_dividend),
    .divisor  (cc_q),
    .quotient (div_quot),
    .busy     (div_busy),
    .done     (div_done)
  );

  // Sequencing is by fixed cycle count, so the divider status is not needed here.
  assign unused_div = div_busy ^ div_done;

  assign bus.ready      = (state_q == StIdle);
  assign bus.FDDX       = fddx_q;
  assign bus.FDDY       = fddy_q;
  assign bus.c          = c_q;
  assign bus.done       = done_q;
  assign bus.coef_valid = valid_q;
  assign bus.degenerate = degen_q;
  assign bus.sat        = sat_q;

endmodule

// File: tb/tb_plane_setup.sv
// Directed bench for plane_setup: hand-computed plane coefficients, latency and control corners.
module tb_plane_setup;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  plane_setup_if #(.OUT_W(32)) bus ();

  plane_setup #(
    .DIV_ITER (64),
    .OUT_W    (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic launch(input logic [7:0] f,
                        input logic signed [31:0] x1, x2, x3, y1, y2, y3, z1, z2, z3);
    @(negedge clock);
    bus.FRAC_BITS = f;
    bus.FX1 = x1; bus.FX2 = x2; bus.FX3 = x3;
    bus.FY1 = y1; bus.FY2 = y2; bus.FY3 = y3;
    bus.FZ1 = z1; bus.FZ2 = z2; bus.FZ3 = z3;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Edges from accept to done, or -1 if done never arrives within the budget.
  task automatic wait_done(output int lat);
    int n;
    lat = -1;
    n = 0;
    while (lat < 0 && n < 400) begin
      @(posedge clock);
      #1;
      n++;
      if (bus.done) lat = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", bus.ready);
    end
    checks++;
    if ({bus.FDDX, bus.FDDY, bus.c} !== 96'd0) begin
      errors++; $display("FAIL reset_coefs got %h %h %h want 0", bus.FDDX, bus.FDDY, bus.c);
    end
    checks++;
    if ({bus.done, bus.coef_valid, bus.degenerate, bus.sat} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.done, bus.coef_valid, bus.degenerate, bus.sat});
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    launch(8'd0, 0, 10, 0, 0, 0, 10, 5, 25, 45);
    checks++;
    if ({bus.ready, bus.coef_valid} !== 2'b00) begin
      errors++; $display("FAIL accept_drop got %b want 00", {bus.ready, bus.coef_valid});
    end
    wait_done(lat);
    checks++;
    if (lat !== 133) begin errors++; $display("FAIL basic_latency got %0d want 133", lat); end
    checks++;
    if (bus.FDDX !== 32'sd2) begin errors++; $display("FAIL basic_fddx got %0d want 2", bus.FDDX); end
    checks++;
    if (bus.FDDY !== 32'sd4) begin errors++; $display("FAIL basic_fddy got %0d want 4", bus.FDDY); end
    checks++;
    if (bus.c !== 32'sd5) begin errors++; $display("FAIL basic_c got %0d want 5", bus.c); end
    checks++;
    if ({bus.degenerate, bus.sat, bus.coef_valid, bus.ready} !== 4'b0011) begin
      errors++;
      $display("FAIL basic_flags got %b want 0011",
               {bus.degenerate, bus.sat, bus.coef_valid, bus.ready});
    end
    @(posedge clock);
    #1;
    checks++;
    if ({bus.done, bus.coef_valid} !== 2'b01) begin
      errors++; $display("FAIL done_pulse got %b want 01", {bus.done, bus.coef_valid});
    end
  endtask

  task automatic test_frac8();
    int lat;
    launch(8'd8, 0, 2560, 0, 0, 0, 2560, 1280, 6400, 11520);
    wait_done(lat);
    checks++;
    if (lat !== 133) begin errors++; $display("FAIL frac8_latency got %0d want 133", lat); end
    checks++;
    if ({bus.FDDX, bus.FDDY, bus.c} !== {32'sd512, 32'sd1024, 32'sd1280}) begin
      errors++;
      $display("FAIL frac8_coefs got %0d %0d %0d want 512 1024 1280", bus.FDDX, bus.FDDY, bus.c);
    end
  endtask

  task automatic test_offset();
    int lat;
    launch(8'd0, 2, 12, 2, 3, 3, 13, 5, 25, 45);
    wait_done(lat);
    checks++;
    if ({bus.FDDX, bus.FDDY} !== {32'sd2, 32'sd4}) begin
      errors++; $display("FAIL offset_slopes got %0d %0d want 2 4", bus.FDDX, bus.FDDY);
    end
    checks++;
    if (bus.c !== -32'sd11) begin errors++; $display("FAIL offset_c got %0d want -11", bus.c); end
  endtask

  task automatic test_collinear();
    int lat;
    launch(8'd0, 0, 1, 2, 0, 1, 2, 7, 9, 11);
    wait_done(lat);
    checks++;
    if (lat !== 133) begin errors++; $display("FAIL degen_latency got %0d want 133", lat); end
    checks++;
    if ({bus.FDDX, bus.FDDY, bus.c} !== {32'sd0, 32'sd0, 32'sd7}) begin
      errors++;
      $display("FAIL degen_coefs got %0d %0d %0d want 0 0 7", bus.FDDX, bus.FDDY, bus.c);
    end
    checks++;
    if ({bus.degenerate, bus.sat} !== 2'b10) begin
      errors++; $display("FAIL degen_flags got %b want 10", {bus.degenerate, bus.sat});
    end
  endtask

  task automatic test_saturate();
    int lat;
    launch(8'd16, 0, 32'h100, 0, 0, 0, 32'h100, 0, 32'h7FFF0000, 0);
    wait_done(lat);
    checks++;
    if (bus.FDDX !== 32'sh7FFFFFFF) begin
      errors++; $display("FAIL sat_fddx got %h want 7fffffff", bus.FDDX);
    end
    checks++;
    if ({bus.FDDY, bus.c} !== 64'd0) begin
      errors++; $display("FAIL sat_others got %h %h want 0 0", bus.FDDY, bus.c);
    end
    checks++;
    if ({bus.sat, bus.degenerate} !== 2'b10) begin
      errors++; $display("FAIL sat_flags got %b want 10", {bus.sat, bus.degenerate});
    end
  endtask

  // Accept counts as cycle 10 of the run; a second start at cycle 50 lands mid-divide.
  task automatic test_busy_start();
    int ndone, done_at;
    ndone = 0;
    done_at = -1;
    launch(8'd0, 0, 10, 0, 0, 0, 10, 5, 25, 45);
    for (int k = 1; k <= 250; k++) begin
      @(negedge clock);
      bus.start = (k == 40);
      @(posedge clock);
      #1;
      if (bus.done) begin ndone++; done_at = k; end
      if (k == 40) begin
        checks++;
        if ({bus.FDDX, bus.sat, bus.coef_valid} !== {32'sh7FFFFFFF, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL busy_hold got %h %b %b want 7fffffff 1 0",
                   bus.FDDX, bus.sat, bus.coef_valid);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL busy_single_done got %0d want 1", ndone); end
    checks++;
    if (done_at !== 133) begin errors++; $display("FAIL busy_done_at got %0d want 133", done_at); end
    checks++;
    if (bus.FDDX !== 32'sd2) begin errors++; $display("FAIL busy_fddx got %0d want 2", bus.FDDX); end
  endtask

  task automatic test_reset_abort();
    int ndone, lat;
    ndone = 0;
    launch(8'd8, 0, 2560, 0, 0, 0, 2560, 1280, 6400, 11520);
    repeat (49) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", bus.ready); end
    checks++;
    if ({bus.FDDX, bus.FDDY, bus.c, bus.done, bus.coef_valid, bus.degenerate, bus.sat} !== 100'd0)
    begin
      errors++;
      $display("FAIL abort_outputs got %h %h %h %b want all 0", bus.FDDX, bus.FDDY, bus.c,
               {bus.done, bus.coef_valid, bus.degenerate, bus.sat});
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    launch(8'd0, 2, 12, 2, 3, 3, 13, 5, 25, 45);
    wait_done(lat);
    checks++;
    if (lat !== 133) begin errors++; $display("FAIL rerun_latency got %0d want 133", lat); end
    checks++;
    if ({bus.FDDX, bus.FDDY, bus.c} !== {32'sd2, 32'sd4, -32'sd11}) begin
      errors++;
      $display("FAIL rerun_coefs got %0d %0d %0d want 2 4 -11", bus.FDDX, bus.FDDY, bus.c);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.FRAC_BITS = '0;
    bus.FX1 = '0; bus.FX2 = '0; bus.FX3 = '0;
    bus.FY1 = '0; bus.FY2 = '0; bus.FY3 = '0;
    bus.FZ1 = '0; bus.FZ2 = '0; bus.FZ3 = '0;
    test_reset();
    test_basic();
    test_frac8();
    test_offset();
    test_collinear();
    test_saturate();
    test_busy_start();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/plane_setup.md
Name: plane_setup

Overview:
- Sequential triangle plane-equation setup engine; the producer side of the PVR per-pixel interpolator.
- Takes three vertices (X, Y, attribute Z) in signed fixed point and computes the plane coefficients FDDX, FDDY and c, so that attr(x,y) = x*FDDX + y*FDDY + c.
- Division is done with an iterative restoring divider.
- Coefficients are held stable after completion so the interpolator can sample them for a whole tile.

Parameters:
- DIV_ITER, 64: quotient bits per divide, one bit per clock; also fixes latency.
- OUT_W, 32: width of FDDX, FDDY and c outputs (signed, saturated).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE
- FRAC_BITS  in  8  fixed-point fraction bits, legal 0..16; sampled at accept
- FX1, FX2, FX3  in  32 each  signed vertex X
- FY1, FY2, FY3  in  32 each  signed vertex Y
- FZ1, FZ2, FZ3  in  32 each  signed vertex attribute
- FDDX  out  OUT_W  signed d(attr)/dx
- FDDY  out  OUT_W  signed d(attr)/dy
- c  out  OUT_W  signed plane constant
- done  out  1  one-cycle pulse when results update
- coef_valid  out  1  level; high from done until the next accept or reset
- degenerate  out  1  C==0 for the last triangle
- sat  out  1  any result clamped for the last triangle

Behaviour:
- Reset: all outputs 0 except ready=1; state IDLE; divider cleared. Reset mid-operation aborts immediately with the same values.
- Accept: start & ready at edge E0 latches all nine vertex inputs and FRAC_BITS. ready drops. coef_valid drops. FDDX, FDDY and c keep their old values until the done edge.
- start while busy is ignored; there is no queueing.
- State sequence and cycle counts:
  - DIFF (1): 64-bit sign-extended differences.
  - MUL (1): six products, each arithmetic-shifted right by FRAC_BITS.
  - CROSS (1): Aa = m(dZ31,dY21) - m(dZ21,dY31); Ba = m(dX31,dZ21) - m(dX21,dZ31); C = m(dX31,dY21) - m(dX21,dY31). Note the operand order of C: it already carries the negation, so ddx = Aa/C and ddy = Ba/C.
  - DIV_X (DIV_ITER): FDDX = (Aa << FRAC_BITS) / C.
  - DIV_Y (DIV_ITER): FDDY = (Ba << FRAC_BITS) / C.
  - CMUL (1): (FDDX*FX1)>>>FRAC_BITS and (FDDY*FY1)>>>FRAC_BITS, using the unsaturated quotients.
  - CSUM (1): c = FZ1 - both products.
  - Return to IDLE.
- Latency: outputs, done and coef_valid update at edge E0+5+2*DIV_ITER (133 at default). ready returns high on that same edge.
- Latency is fixed, independent of the data.
- Divide: magnitudes are divided, then the sign is applied, so results truncate toward zero. The dividend is 64-bit; a dividend overflowing 64 bits is clamped.
- Outputs saturate to the OUT_W signed range (0x7FFFFFFF / 0x80000000) and set sat.
- C==0: divides are skipped, but latency stays unchanged. Results are FDDX=0, FDDY=0, c=FZ1, with degenerate=1.
- degenerate and sat update on the done edge and hold until the next done or reset.

Decomposition:
- Shared package pvr_setup_pkg: state enum; constants for the OUT_W saturation limits and the maximum FRAC_BITS (16); 64-bit signed intermediate typedef.
- One sub-module, seq_div_s64: signed iterative restoring divider. Interface: clock, reset, go, dividend[64], divisor[64], quotient[64], busy, done; fixed DIV_ITER cycles. It is instanced once and reused for DIV_X then DIV_Y.

Test Plan:
- FRAC_BITS=0; X=(0,10,0), Y=(0,0,10), Z=(5,25,45) -> FDDX=2, FDDY=4, c=5, degenerate=0, sat=0. done exactly 133 edges after accept.
- FRAC_BITS=8; X=(0,2560,0), Y=(0,0,2560), Z=(1280,6400,11520) -> C=-25600, FDDX=512, FDDY=1024, c=1280.
- FRAC_BITS=0; X=(2,12,2), Y=(3,3,13), Z=(5,25,45) -> FDDX=2, FDDY=4, c=-11.
- Collinear X=(0,1,2), Y=(0,1,2), Z=(7,9,11) -> FDDX=0, FDDY=0, c=7, degenerate=1, still 133-cycle latency.
- FRAC_BITS=16; X=(0,0x100,0), Y=(0,0,0x100), Z=(0,0x7FFF0000,0) -> C=-1, FDDX=0x7FFFFFFF, sat=1.
- start pulsed at cycles 10 and 50 of a run -> second start ignored, single done. Reset asserted at cycle 60 -> next edge ready=1, all outputs 0. A new start afterwards completes normally.
